// File: rtl/hrv_pkg.sv
// Shared types and constants for the HRV datapath: FSM state encodings,
// RR value width and the saturating increment used by the interval counter.
package hrv_pkg;

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        MEASURE    = 1'b1
    } meas_state_t;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    localparam int              RR_W   = 8;
    localparam logic [RR_W-1:0] RR_MAX = 8'hFF;

    function automatic logic [RR_W-1:0] sat_inc(input logic [RR_W-1:0] value);
        logic [RR_W-1:0] result;
        if (value == RR_MAX) begin
            result = RR_MAX;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/beat_sync_edge.sv
// Brings the asynchronous R-peak pulse into the clk domain and turns each
// rising edge into a registered single-cycle beat event.
module beat_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic beat_in,
    output logic beat_evt
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;
    logic evt_r;

    // Two-flop synchronizer, one history flop, and the registered edge pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            evt_r   <= 1'b0;
        end else begin
            sync1_r <= beat_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            evt_r   <= sync2_r & ~prev_r;
        end
    end

    assign beat_evt = evt_r;

endmodule

// File: rtl/rr_interval_serializer.sv
// Measures the time between accepted heartbeats in prescaled ticks and ships
// each 8-bit interval MSB-first over the bit-serial link, with one spare slot.
module rr_interval_serializer #(
    parameter int TICK_DIV = 1000,
    parameter int MIN_RR   = 30,
    parameter int RR_W     = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            beat_in,
    output logic            bit_out,
    output logic            bit_valid,
    output logic            rr_valid,
    output logic            busy,
    output logic            overflow,
    output logic [RR_W-1:0] rr_count
);
    import hrv_pkg::*;

    localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);
    localparam logic [PW-1:0]   PRESC_TERM = PW'(TICK_DIV - 1);
    localparam logic [RR_W-1:0] RR_ZERO    = {RR_W{1'b0}};
    localparam logic [RR_W-1:0] RR_ONE     = RR_W'(1);
    localparam logic [RR_W-1:0] RR_MIN     = RR_W'(MIN_RR);
    localparam logic [2:0]      LAST_IDX   = 3'(RR_W - 1);
    localparam logic [2:0]      PRE_LAST   = 3'(RR_W - 2);

    logic            beat_evt_s;
    logic            tick_s;
    logic [PW-1:0]   presc_next_s;
    logic [RR_W-1:0] rr_next_s;
    logic            cap_s;

    meas_state_t     meas_r;
    logic [PW-1:0]   presc_r;
    logic [RR_W-1:0] rr_cnt_r;

    logic            ser_idle_s;
    logic            last_s;
    logic            load_pend_s;
    logic            load_cap_s;
    logic            load_s;
    logic            cap_to_pend_s;
    logic            drop_s;
    logic [RR_W-1:0] load_val_s;
    ser_state_t      ser_next_s;
    logic            pend_full_next_s;

    ser_state_t      ser_r;
    logic [RR_W-1:0] shreg_r;
    logic [2:0]      idx_r;
    logic [RR_W-1:0] pend_r;
    logic            pend_full_r;
    logic            bit_out_r;
    logic            bit_valid_r;
    logic            rr_valid_r;
    logic            busy_r;
    logic            overflow_r;
    logic [RR_W-1:0] rr_count_r;

    beat_sync_edge u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .beat_in  (beat_in),
        .beat_evt (beat_evt_s)
    );

    assign tick_s = (presc_r == PRESC_TERM);

    // Interval value as it would stand after this edge; a tick landing in
    // the beat cycle is counted so N*TICK_DIV clocks measure exactly N.
    always_comb begin
        presc_next_s = PRESC_ZERO;
        rr_next_s    = rr_cnt_r;
        cap_s        = 1'b0;
        if (tick_s) begin
            presc_next_s = PRESC_ZERO;
            rr_next_s    = sat_inc(rr_cnt_r);
        end else begin
            presc_next_s = presc_r + PRESC_ONE;
            rr_next_s    = rr_cnt_r;
        end
        if ((meas_r == MEASURE) && beat_evt_s && (rr_next_s >= RR_MIN)) begin
            cap_s = 1'b1;
        end else begin
            cap_s = 1'b0;
        end
    end

    // Prescaler, saturating interval counter and beat-acceptance FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meas_r   <= WAIT_FIRST;
            presc_r  <= PRESC_ZERO;
            rr_cnt_r <= RR_ZERO;
        end else begin
            case (meas_r)
                WAIT_FIRST: begin
                    rr_cnt_r <= RR_ZERO;
                    if (beat_evt_s) begin
                        meas_r  <= MEASURE;
                        presc_r <= PRESC_ZERO;
                    end else begin
                        presc_r <= presc_next_s;
                    end
                end
                MEASURE: begin
                    if (cap_s) begin
                        presc_r  <= PRESC_ZERO;
                        rr_cnt_r <= RR_ZERO;
                    end else begin
                        presc_r  <= presc_next_s;
                        rr_cnt_r <= rr_next_s;
                    end
                end
                default: begin
                    meas_r   <= WAIT_FIRST;
                    presc_r  <= PRESC_ZERO;
                    rr_cnt_r <= RR_ZERO;
                end
            endcase
        end
    end

    // Route a captured value: straight to an idle serializer, else into the
    // spare slot if it is (or is about to be) free, else drop it.
    always_comb begin
        ser_idle_s    = (ser_r == SER_IDLE);
        last_s        = (ser_r == SER_SHIFT) && (idx_r == LAST_IDX);
        load_pend_s   = pend_full_r && (ser_idle_s || last_s);
        load_cap_s    = cap_s && ser_idle_s && !pend_full_r;
        load_s        = load_pend_s || load_cap_s;
        cap_to_pend_s = cap_s && !load_cap_s && (!pend_full_r || load_pend_s);
        drop_s        = cap_s && !load_cap_s && !cap_to_pend_s;
        load_val_s    = RR_ZERO;
        if (load_pend_s) begin
            load_val_s = pend_r;
        end else begin
            load_val_s = rr_next_s;
        end
        ser_next_s = ser_r;
        if (load_s) begin
            ser_next_s = SER_SHIFT;
        end else if (last_s) begin
            ser_next_s = SER_IDLE;
        end else begin
            ser_next_s = ser_r;
        end
        pend_full_next_s = pend_full_r;
        if (cap_to_pend_s) begin
            pend_full_next_s = 1'b1;
        end else if (load_pend_s) begin
            pend_full_next_s = 1'b0;
        end else begin
            pend_full_next_s = pend_full_r;
        end
    end

    // Serializer shift path, pending slot and all registered link outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ser_r       <= SER_IDLE;
            shreg_r     <= RR_ZERO;
            idx_r       <= 3'd0;
            pend_r      <= RR_ZERO;
            pend_full_r <= 1'b0;
            bit_out_r   <= 1'b0;
            bit_valid_r <= 1'b0;
            rr_valid_r  <= 1'b0;
            busy_r      <= 1'b0;
            overflow_r  <= 1'b0;
            rr_count_r  <= RR_ZERO;
        end else begin
            ser_r       <= ser_next_s;
            pend_full_r <= pend_full_next_s;
            busy_r      <= (ser_next_s == SER_SHIFT) || pend_full_next_s;
            overflow_r  <= overflow_r || drop_s;
            if (cap_to_pend_s) begin
                pend_r <= rr_next_s;
            end else begin
                pend_r <= pend_r;
            end
            if (load_s) begin
                bit_out_r   <= load_val_s[RR_W-1];
                shreg_r     <= {load_val_s[RR_W-2:0], 1'b0};
                idx_r       <= 3'd0;
                bit_valid_r <= 1'b1;
                rr_valid_r  <= 1'b0;
            end else if ((ser_r == SER_SHIFT) && !last_s) begin
                bit_out_r   <= shreg_r[RR_W-1];
                shreg_r     <= {shreg_r[RR_W-2:0], 1'b0};
                idx_r       <= idx_r + 3'd1;
                bit_valid_r <= 1'b1;
                rr_valid_r  <= (idx_r == PRE_LAST);
                if (idx_r == PRE_LAST) begin
                    rr_count_r <= rr_count_r + RR_ONE;
                end else begin
                    rr_count_r <= rr_count_r;
                end
            end else begin
                bit_out_r   <= 1'b0;
                bit_valid_r <= 1'b0;
                rr_valid_r  <= 1'b0;
            end
        end
    end

    assign bit_out   = bit_out_r;
    assign bit_valid = bit_valid_r;
    assign rr_valid  = rr_valid_r;
    assign busy      = busy_r;
    assign overflow  = overflow_r;
    assign rr_count  = rr_count_r;

endmodule

// File: doc/rr_interval_serializer.md
# rr_interval_serializer

Upstream stage of the HRV datapath: converts a raw heartbeat (R-peak) pulse into 8-bit RR-interval values measured in prescaled ticks. It serializes each value MSB-first onto the bit-serial link consumed by the RMSSD stage (bit_in / bit_valid / rr_valid). It handles input synchronization, refractory rejection of spurious beats, counter saturation, and one-deep buffering when a new interval is ready while the previous one is still shifting.

## Interface
Parameters:
- TICK_DIV, 1000: clk cycles per RR tick (≥2).
- MIN_RR, 30: minimum accepted interval in ticks; beats arriving earlier are ignored (refractory).
- RR_W, 8: RR value width (fixed 8 for the downstream link).

Ports:
- clk, in, 1: single clock domain.
- rst_n, in, 1: asynchronous, active-low reset.
- beat_in, in, 1: raw asynchronous R-peak pulse, active high, ≥1 clk wide.
- bit_out, out, 1: serial RR data, MSB first. Drives the downstream bit_in.
- bit_valid, out, 1: bit_out valid this cycle.
- rr_valid, out, 1: asserted together with the 8th (LSB) bit of each value.
- busy, out, 1: serializer shifting or pending register full.
- overflow, out, 1: sticky; an interval was dropped. Cleared only by reset.
- rr_count, out, 8: number of intervals emitted. Wraps 255→0.

## Operation
- Input conditioning: beat_in passes through a 2-FF synchronizer, then a rising-edge detect, producing a 1-cycle beat_evt.
- Prescaler:
  - Counts 0..TICK_DIV-1 and pulses tick on the terminal count.
  - Resets to 0 on every accepted beat.
- Measure FSM, states WAIT_FIRST and MEASURE:
  - WAIT_FIRST: on beat_evt, clear rr_cnt and the prescaler, then go to MEASURE. Nothing is emitted.
  - MEASURE: rr_cnt increments on each tick and saturates at 255 (no wrap).
  - MEASURE, beat_evt with rr_cnt ≥ MIN_RR: capture rr_cnt and clear rr_cnt and the prescaler. Stay in MEASURE.
  - MEASURE, beat_evt with rr_cnt < MIN_RR: ignore the beat. The count continues.
- Captured value routing:
  - Serializer idle: the captured value goes to the serializer.
  - Serializer shifting and pending empty: the value goes to pending.
  - Pending full: the value is dropped and overflow is set.
- Serializer, states IDLE and SHIFT:
  - SHIFT emits 8 bits over 8 consecutive cycles with bit_valid=1. rr_valid=1 only on the 8th cycle.
  - rr_count increments in the cycle rr_valid is high.
  - After the 8th bit: if pending is full, load it and start shifting on the very next cycle (back-to-back). Otherwise return to IDLE.
- Capture in the same cycle as the serializer's 8th bit:
  - If pending is empty, the value goes to pending and is loaded next cycle.
  - If pending is full, pending is loaded and the new value moves into pending. No drop occurs.
- Reset mid-operation:
  - All state clears immediately. A partial word is abandoned: bit_valid and rr_valid drop to 0 asynchronously.
  - The FSM returns to WAIT_FIRST.
- Reset values: bit_out=0, bit_valid=0, rr_valid=0, busy=0, overflow=0, rr_count=0.

## Timing
- beat_in rising edge sampled at clk edge E: beat_evt is high in cycle E+2.
- Value captured at the end of the beat_evt cycle. First bit (MSB) appears at E+3, LSB and rr_valid at E+10.
- Capture-to-first-bit latency is 1 cycle. Beat-edge-to-rr_valid latency is 10 cycles.
- All outputs are registered.
- bit_valid is never high for more than 8 consecutive cycles, except during a back-to-back pending load (16 cycles).

## Structure
- The shared package hrv_pkg holds:
  - measure state enum {WAIT_FIRST, MEASURE}
  - serializer state enum {SER_IDLE, SER_SHIFT}
  - RR_W constant
  - RR_MAX = 8'hFF
- One sub-module, beat_sync_edge: 2-FF synchronizer plus rising-edge detect, async active-low reset, outputs beat_evt.
- The prescaler, measure FSM, pending register and serializer live in the top module.

## Test plan
All scenarios use TICK_DIV=4 and MIN_RR=3.
1. Basic interval: beats 40 clks apart.
   - First beat emits nothing.
   - Second beat gives bit stream 0,0,0,0,1,0,1,0 (rr=10), rr_valid on the last bit, rr_count=1.
2. Refractory: extra beat 8 clks after an accepted beat.
   - The extra beat is ignored.
   - The next beat 40 clks after the accepted one yields rr=10, not 2 or 8.
3. Saturation: 1200 clks between beats.
   - Emitted value 0xFF (all ones).
   - No wrap to a small value.
4. Back-to-back and overflow: shrink the serializer window with TICK_DIV=2, MIN_RR=1, beats every 3 clks.
   - The second value is held in pending and emitted immediately after the first (16 contiguous bit_valid cycles).
   - The third value is dropped and overflow=1.
5. Reset mid-word: assert rst_n=0 after the 4th bit.
   - All outputs are 0 asynchronously.
   - After release, the first beat emits nothing (WAIT_FIRST).
   - A subsequent 40-clk interval emits 10.
6. Downstream compatibility: connect to the RMSSD stage and feed 9 beats 40 clks apart.
   - 8 values of 10 are delivered.
   - The RMSSD stage asserts done with result 0.
